// File: rtl/mult_share_ctrl.sv
// Two-requester front end for one shift-add multiplier that adds one operand per cycle.
// Ties between requesters are resolved round-robin; a finished product is held until the consumer takes it.
module mult_share_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [2*WIDTH-1:0]   resp_pro,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for a request, ready goes to the granted requester
    // MULT  | one shift-add step per cycle, WIDTH cycles
    // DONE  | product presented until resp_valid && resp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mult_q;
    logic [WIDTH-1:0]   acc_hi;
    logic [CNT_W-1:0]   cnt;
    logic               id_q;
    logic               last_served;
    logic               grant_vld;
    logic               grant_id;
    logic [WIDTH:0]     sum;
    logic               last_step;

    assign grant_vld = req0_valid | req1_valid;
    // On a tie the requester that was not served last wins.
    assign grant_id  = (req0_valid & req1_valid) ? ~last_served : req1_valid;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign sum       = {1'b0, acc_hi} + (mult_q[0] ? {1'b0, a_q} : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant_vld & ~grant_id;
                req1_ready = grant_vld & grant_id;
                if (grant_vld) begin
                    state_nxt = MULT;
                end
            end
            MULT: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            mult_q      <= '0;
            acc_hi      <= '0;
            cnt         <= '0;
            id_q        <= 1'b0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        a_q         <= grant_id ? req1_a : req0_a;
                        mult_q      <= grant_id ? req1_b : req0_b;
                        acc_hi      <= '0;
                        cnt         <= '0;
                        id_q        <= grant_id;
                        last_served <= grant_id;
                    end
                end
                MULT: begin
                    // {carry, acc_hi, multiplier} shifts right; product bits fill the multiplier register.
                    acc_hi <= sum[WIDTH:1];
                    mult_q <= {sum[0], mult_q[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_valid = (state == DONE);
    assign resp_pro   = resp_valid ? {acc_hi, mult_q} : '0;
    assign resp_id    = resp_valid & id_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: boundary products, latency, arbitration, back-pressure and reset abort.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mult_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        req1_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_id;
    logic [63:0] resp_pro;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int both_rdy = 0;
    int rdy_busy = 0;

    mult_share_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_pro   (resp_pro),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (req0_ready && req1_ready) both_rdy++;
        if (busy && (req0_ready || req1_ready)) rdy_busy++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input string tag, output bit id);
        int  t;
        bit  ok;
        t  = 0;
        ok = 1'b0;
        id = 1'b0;
        #1;
        while (t < 60) begin
            if (req0_ready || req1_ready) begin
                ok = 1'b1;
                id = req1_ready;
                break;
            end
            @(negedge clk);
            t++;
        end
        check({tag, "_grant_seen"}, 64'(ok), 64'd1);
    endtask

    // Called on the falling edge after the acceptance edge; lat counts rising edges since acceptance.
    task automatic wait_resp(input string tag, output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_resp_seen"}, 64'(resp_valid), 64'd1);
    endtask

    task automatic single(input string tag, input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        bit g;
        int lat;
        resp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        wait_grant(tag, g);
        check({tag, "_gid"}, 64'(g), 64'(id));
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_pro_zero"}, resp_pro, 64'd0);
        wait_resp(tag, lat);
        check({tag, "_lat"}, 64'(lat), 64'd32);
        check({tag, "_pro"}, resp_pro, exp);
        check({tag, "_id"}, 64'(resp_id), 64'(id));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          g;
        bit          exp_next;
        bit          hs;
        int          lat;
        int          spur;
        int          w;
        logic [31:0] a0, b0, a1, b1, ea, eb;
        logic [63:0] ep;

        do_reset();
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_pro", resp_pro, 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_ready1", 64'(req1_ready), 64'd0);

        single("small", 1'b0, 32'd3, 32'd5, 64'd15);
        single("max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        single("zero_a", 1'b0, 32'd0, 32'h1234_5678, 64'd0);
        single("zero_b", 1'b1, 32'hDEAD_BEEF, 32'd0, 64'd0);
        single("one", 1'b0, 32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
        single("msb", 1'b1, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
        single("carry", 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        single("nibble", 1'b1, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);

        // Contention straight out of reset: requester 0 wins the first tie.
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd7;       req0_b = 32'd6;
        req1_valid = 1'b1; req1_a = 32'h1_0000;  req1_b = 32'h1_0000;
        #1;
        check("cont_ready0", 64'(req0_ready), 64'd1);
        check("cont_ready1", 64'(req1_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        check("cont_wait_ready1", 64'(req1_ready), 64'd0);
        wait_resp("cont0", lat);
        check("cont0_lat", 64'(lat), 64'd32);
        check("cont0_pro", resp_pro, 64'd42);
        check("cont0_id", 64'(resp_id), 64'd0);
        check("cont0_done_ready1", 64'(req1_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("cont1_ready1", 64'(req1_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp("cont1", lat);
        check("cont1_lat", 64'(lat), 64'd32);
        check("cont1_pro", resp_pro, 64'h0000_0001_0000_0000);
        check("cont1_id", 64'(resp_id), 64'd1);
        @(posedge clk);
        @(negedge clk);

        // Back-pressure: product and id held, no acceptance while DONE.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h10;
        wait_grant("bp", g);
        @(posedge clk);
        @(negedge clk);
        wait_resp("bp", lat);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_pro", resp_pro, 64'h0000_0001_2345_6780);
            check("bp_id", 64'(resp_id), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_ready0", 64'(req0_ready), 64'd0);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_rel_busy", 64'(busy), 64'd0);
        check("bp_rel_valid", 64'(resp_valid), 64'd0);
        check("bp_rel_pro", resp_pro, 64'd0);

        // Abort in the middle of MULT (count 15).
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9;
        wait_grant("abort", g);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(resp_valid), 64'd0);
        check("abort_pro", resp_pro, 64'd0);
        check("abort_id", 64'(resp_id), 64'd0);
        // Tie right after reset goes to requester 0; withdrawing before an edge accepts nothing.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("abort_tie_ready0", 64'(req0_ready), 64'd1);
        check("abort_tie_ready1", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        spur = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid || busy) spur++;
        end
        check("abort_no_resp", 64'(spur), 64'd0);
        single("after_abort", 1'b0, 32'd11, 32'd13, 64'd143);

        // Continuous contention: strict alternation, products against a reference multiply.
        exp_next = 1'b1;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        req0_valid = 1'b1; req0_a = a0; req0_b = b0;
        req1_valid = 1'b1; req1_a = a1; req1_b = b1;
        for (int i = 0; i < 24; i++) begin
            wait_grant("rr", g);
            check("rr_order", 64'(g), 64'(exp_next));
            ea = g ? a1 : a0;
            eb = g ? b1 : b0;
            ep = 64'(ea) * 64'(eb);
            @(posedge clk);
            @(negedge clk);
            if (g) begin
                a1 = $urandom; b1 = $urandom; req1_a = a1; req1_b = b1;
            end else begin
                a0 = $urandom; b0 = $urandom; req0_a = a0; req0_b = b0;
            end
            wait_resp("rr", lat);
            check("rr_lat", 64'(lat), 64'd32);
            check("rr_pro", resp_pro, ep);
            check("rr_id", 64'(resp_id), 64'(g));
            w = 0;
            do begin
                resp_ready = (w >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk);
                hs = resp_ready;
                @(negedge clk);
                if (!hs) check("rr_hold_pro", resp_pro, ep);
                w++;
            end while (!hs);
            exp_next = ~g;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);

        check("never_both_ready", 64'(both_rdy), 64'd0);
        check("no_ready_while_busy", 64'(rdy_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
